// File: rtl/mem_arb.sv
// mem_arb - single-port memory arbiter between instruction fetch (IF) and data access (MA).
//
// Both requesters hold their request until granted. Grants are combinational in the
// request cycle. The address and write data are muxed onto the memory port. Read data
// goes back to the owner one cycle later. A starvation counter bounds how many
// consecutive MA grants IF can lose, so fetch always makes progress.
//
// Ports
//   iw_clk, iw_rst                  clock (rising edge), async active-high reset
//   iw_if_req/iw_if_addr            fetch read request and address
//   iw_if_flush                     discard fetch read data returning this cycle
//   ow_if_gnt                       fetch granted this cycle (comb)
//   or_if_rvalid/ow_if_rdata        fetch read return
//   iw_ma_req/we/addr/wdata         data request (we=1 write)
//   ow_ma_gnt                       data granted this cycle (comb)
//   or_ma_rvalid/ow_ma_rdata        data read return
//   ow_mem_we/addr/wdata            memory port outputs
//   iw_mem_rdata                    memory read data, valid 1 cycle after address
//   or_stall_cnt                    saturating count of cycles IF waited
module mem_arb #(
   parameter int unsigned SIZE_ADDR    = 8,
   parameter int unsigned SIZE_DATA    = 8,
   parameter int unsigned P_STARVE_MAX = 3,
   parameter int unsigned P_STARVE_W   = 2,
   parameter int unsigned P_STALL_W    = 16
) (
   input  logic                 iw_clk,
   input  logic                 iw_rst,
   input  logic                 iw_if_req,
   input  logic [SIZE_ADDR-1:0] iw_if_addr,
   input  logic                 iw_if_flush,
   output logic                 ow_if_gnt,
   output logic                 or_if_rvalid,
   output logic [SIZE_DATA-1:0] ow_if_rdata,
   input  logic                 iw_ma_req,
   input  logic                 iw_ma_we,
   input  logic [SIZE_ADDR-1:0] iw_ma_addr,
   input  logic [SIZE_DATA-1:0] iw_ma_wdata,
   output logic                 ow_ma_gnt,
   output logic                 or_ma_rvalid,
   output logic [SIZE_DATA-1:0] ow_ma_rdata,
   output logic                 ow_mem_we,
   output logic [SIZE_ADDR-1:0] ow_mem_addr,
   output logic [SIZE_DATA-1:0] ow_mem_wdata,
   input  logic [SIZE_DATA-1:0] iw_mem_rdata,
   output logic [P_STALL_W-1:0] or_stall_cnt
);

   // State holds the owner of the previous cycle's grant, which is the owner of the
   // read data arriving this cycle.
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_IF    = 2'd1;
   localparam logic [1:0] S_MA_RD = 2'd2;
   localparam logic [1:0] S_MA_WR = 2'd3;

   localparam logic [P_STARVE_W-1:0] L_STARVE_MAX = P_STARVE_W'(P_STARVE_MAX);

   logic [1:0]            r_state;
   logic [1:0]            w_state_nxt;
   logic [P_STARVE_W-1:0] r_starve_cnt;
   logic [P_STARVE_W-1:0] w_starve_nxt;
   logic [P_STALL_W-1:0]  r_stall_cnt;
   logic [P_STALL_W-1:0]  w_stall_nxt;
   logic                  w_force_if;
   logic                  w_if_gnt;
   logic                  w_ma_gnt;

   // Grant: MA wins unless IF has lost too many times in a row.
   assign w_force_if = (r_starve_cnt == L_STARVE_MAX);
   assign w_ma_gnt   = iw_ma_req & ~(w_force_if & iw_if_req);
   assign w_if_gnt   = iw_if_req & ~w_ma_gnt;

   assign ow_if_gnt  = w_if_gnt;
   assign ow_ma_gnt  = w_ma_gnt;

   // An idle cycle issues a harmless read of the fetch address.
   always_comb begin
      ow_mem_we    = 1'b0;
      ow_mem_addr  = iw_if_addr;
      ow_mem_wdata = iw_ma_wdata;
      if (w_ma_gnt) begin
         ow_mem_we   = iw_ma_we;
         ow_mem_addr = iw_ma_addr;
      end
   end

   always_comb begin
      w_state_nxt = S_IDLE;
      if (w_if_gnt) begin
         w_state_nxt = S_IF;
      end else if (w_ma_gnt && !iw_ma_we) begin
         w_state_nxt = S_MA_RD;
      end else if (w_ma_gnt) begin
         w_state_nxt = S_MA_WR;
      end
   end

   always_comb begin
      w_starve_nxt = r_starve_cnt;
      if (w_if_gnt || !iw_if_req) begin
         w_starve_nxt = '0;
      end else if (w_ma_gnt && (r_starve_cnt != L_STARVE_MAX)) begin
         w_starve_nxt = r_starve_cnt + 1'b1;
      end
   end

   always_comb begin
      w_stall_nxt = r_stall_cnt;
      if (iw_if_req && !w_if_gnt && (r_stall_cnt != {P_STALL_W{1'b1}})) begin
         w_stall_nxt = r_stall_cnt + 1'b1;
      end
   end

   always_ff @(posedge iw_clk or posedge iw_rst) begin
      if (iw_rst) begin
         r_state      <= S_IDLE;
         r_starve_cnt <= '0;
         r_stall_cnt  <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_starve_cnt <= w_starve_nxt;
         r_stall_cnt  <= w_stall_nxt;
      end
   end

   // Flush suppresses only the return landing this cycle. Reset clears the state, so an
   // in-flight read is dropped.
   assign or_if_rvalid = (r_state == S_IF) & ~iw_if_flush;
   assign or_ma_rvalid = (r_state == S_MA_RD);
   assign ow_if_rdata  = iw_mem_rdata;
   assign ow_ma_rdata  = iw_mem_rdata;
   assign or_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_mem_arb.sv
module tb_mem_arb;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       if_req = 1'b0, if_flush = 1'b0, ma_req = 1'b0, ma_we = 1'b0;
   logic [7:0] if_addr = '0, ma_addr = '0, ma_wdata = '0;
   logic       if_gnt, if_rvalid, ma_gnt, ma_rvalid, mem_we;
   logic [7:0] if_rdata, ma_rdata, mem_addr, mem_wdata;
   logic [7:0] mem_rdata = '0;
   logic [15:0] stall_cnt;
   logic [7:0] mem [256];

   // Saturation instance: tiny stall counter, starvation bound out of reach.
   logic       s_if_req = 1'b0, s_ma_req = 1'b0;
   logic       s_if_gnt, s_if_rvalid, s_ma_gnt, s_ma_rvalid, s_mem_we;
   logic [7:0] s_if_rdata, s_ma_rdata, s_mem_addr, s_mem_wdata;
   logic [3:0] s_stall_cnt;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mem_arb u_dut (
      .iw_clk(clk), .iw_rst(rst),
      .iw_if_req(if_req), .iw_if_addr(if_addr), .iw_if_flush(if_flush),
      .ow_if_gnt(if_gnt), .or_if_rvalid(if_rvalid), .ow_if_rdata(if_rdata),
      .iw_ma_req(ma_req), .iw_ma_we(ma_we), .iw_ma_addr(ma_addr), .iw_ma_wdata(ma_wdata),
      .ow_ma_gnt(ma_gnt), .or_ma_rvalid(ma_rvalid), .ow_ma_rdata(ma_rdata),
      .ow_mem_we(mem_we), .ow_mem_addr(mem_addr), .ow_mem_wdata(mem_wdata),
      .iw_mem_rdata(mem_rdata), .or_stall_cnt(stall_cnt)
   );

   mem_arb #(
      .P_STARVE_MAX(255), .P_STARVE_W(8), .P_STALL_W(4)
   ) u_sat (
      .iw_clk(clk), .iw_rst(rst),
      .iw_if_req(s_if_req), .iw_if_addr(8'h00), .iw_if_flush(1'b0),
      .ow_if_gnt(s_if_gnt), .or_if_rvalid(s_if_rvalid), .ow_if_rdata(s_if_rdata),
      .iw_ma_req(s_ma_req), .iw_ma_we(1'b0), .iw_ma_addr(8'h01), .iw_ma_wdata(8'h00),
      .ow_ma_gnt(s_ma_gnt), .or_ma_rvalid(s_ma_rvalid), .ow_ma_rdata(s_ma_rdata),
      .ow_mem_we(s_mem_we), .ow_mem_addr(s_mem_addr), .ow_mem_wdata(s_mem_wdata),
      .iw_mem_rdata(8'h00), .or_stall_cnt(s_stall_cnt)
   );

   // Synchronous memory, read-before-write, one cycle latency.
   always @(posedge clk) begin
      mem_rdata <= mem[mem_addr];
      if (mem_we) mem[mem_addr] <= mem_wdata;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; checks happen on the falling edge.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   localparam logic [7:0] MA_PAT = 8'b1110_1110;

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;

      // Reset values
      #2 rst = 1'b1;
      #1;
      chk("rst_if_rvalid", 32'(if_rvalid), 0);
      chk("rst_ma_rvalid", 32'(ma_rvalid), 0);
      chk("rst_stall", 32'(stall_cnt), 0);
      chk("rst_gnts", {30'd0, if_gnt, ma_gnt}, 0);
      chk("rst_mem_we", 32'(mem_we), 0);
      next_cycle();
      rst = 1'b0;

      // IF only: addresses 0,1,2, then idle
      for (int c = 0; c < 4; c++) begin
         if_req  = (c < 3);
         if_addr = 8'(c);
         @(negedge clk);
         chk("if_only_gnt", 32'(if_gnt), 32'(c < 3));
         chk("if_only_rvalid", 32'(if_rvalid), 32'(c > 0));
         if (c > 0) chk("if_only_rdata", 32'(if_rdata), 32'(8'(c - 1) ^ 8'hA5));
         next_cycle();
      end
      chk("if_only_stall", 32'(stall_cnt), 0);

      // Contention: both held 8 cycles -> MA,MA,MA,IF,MA,MA,MA,IF
      if_req = 1'b1; if_addr = 8'h20;
      ma_req = 1'b1; ma_we = 1'b0; ma_addr = 8'h30;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         chk("cont_ma_gnt", 32'(ma_gnt), 32'(MA_PAT[7-c]));
         chk("cont_if_gnt", 32'(if_gnt), 32'(!MA_PAT[7-c]));
         chk("cont_mem_addr", 32'(mem_addr), MA_PAT[7-c] ? 32'h30 : 32'h20);
         if (c > 0) chk("cont_ma_rvalid", 32'(ma_rvalid), 32'(MA_PAT[8-c]));
         next_cycle();
      end
      if_req = 1'b0; ma_req = 1'b0;
      @(negedge clk);
      chk("cont_stall", 32'(stall_cnt), 6);
      chk("cont_last_if_rvalid", 32'(if_rvalid), 1);
      chk("cont_last_if_rdata", 32'(if_rdata), 32'(8'h20 ^ 8'hA5));
      next_cycle();

      // Write 0x5A to 0x10, then read it back
      ma_req = 1'b1; ma_we = 1'b1; ma_addr = 8'h10; ma_wdata = 8'h5A;
      @(negedge clk);
      chk("wr_gnt", 32'(ma_gnt), 1);
      chk("wr_mem_we", 32'(mem_we), 1);
      chk("wr_mem_addr", 32'(mem_addr), 32'h10);
      chk("wr_mem_wdata", 32'(mem_wdata), 32'h5A);
      next_cycle();
      ma_we = 1'b0;
      @(negedge clk);
      chk("rd_mem_we", 32'(mem_we), 0);
      chk("wr_no_rvalid", 32'(ma_rvalid), 0);
      next_cycle();
      ma_req = 1'b0;
      @(negedge clk);
      chk("rd_rvalid", 32'(ma_rvalid), 1);
      chk("rd_rdata", 32'(ma_rdata), 32'h5A);
      chk("rd_if_rvalid", 32'(if_rvalid), 0);
      next_cycle();

      // Flush kills only the return landing in its cycle
      if_req = 1'b1; if_addr = 8'h40;
      @(negedge clk);
      chk("fl_gnt0", 32'(if_gnt), 1);
      next_cycle();
      if_addr = 8'h41; if_flush = 1'b1;
      @(negedge clk);
      chk("fl_gnt1", 32'(if_gnt), 1);
      chk("fl_killed", 32'(if_rvalid), 0);
      next_cycle();
      if_req = 1'b0; if_flush = 1'b0;
      @(negedge clk);
      chk("fl_rvalid", 32'(if_rvalid), 1);
      chk("fl_rdata", 32'(if_rdata), 32'(8'h41 ^ 8'hA5));
      next_cycle();

      // Reset mid-traffic: build up stall, then reset with a read in flight
      if_req = 1'b1; if_addr = 8'h50; ma_req = 1'b1; ma_addr = 8'h51;
      next_cycle();
      @(negedge clk);
      chk("mr_ma_rvalid_pre", 32'(ma_rvalid), 1);
      chk("mr_stall_pre", 32'(stall_cnt), 7);
      rst = 1'b1;
      #1;
      chk("mr_ma_rvalid", 32'(ma_rvalid), 0);
      chk("mr_if_rvalid", 32'(if_rvalid), 0);
      chk("mr_stall", 32'(stall_cnt), 0);
      if_req = 1'b0; ma_req = 1'b0;
      next_cycle();
      rst = 1'b0;
      @(negedge clk);
      chk("mr_post_ma_rvalid", 32'(ma_rvalid), 0);
      chk("mr_post_if_rvalid", 32'(if_rvalid), 0);
      next_cycle();

      // Stall counter saturation on the 4-bit instance
      s_if_req = 1'b1; s_ma_req = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         chk("sat_if_gnt", 32'(s_if_gnt), 0);
         if (c == 10) chk("sat_mid", 32'(s_stall_cnt), 10);
         next_cycle();
      end
      @(negedge clk);
      chk("sat_final", 32'(s_stall_cnt), 15);
      s_if_req = 1'b0; s_ma_req = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
